// File: rtl/dmem_mmio_if.sv
// CPU data-memory bus: byte-addressed, lane-enabled stores and combinational loads.
interface dmem_mmio_if;
    logic [31:0] addr;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic        mem_write;
    logic [31:0] read_data;

    modport master (
        output addr, byte_enable, write_data, mem_write,
        input  read_data
    );

    modport slave (
        input  addr, byte_enable, write_data, mem_write,
        output read_data
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus a small MMIO block: GPIO, a 64-bit mtime/mtimecmp timer and a sticky
// timer interrupt. Loads are combinational from addr; all state changes on CLOCK_50.
module dmem_mmio #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
    parameter int unsigned N_GPIO      = 8,
    parameter int unsigned PRESCALE    = 50
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    dmem_mmio_if.slave        bus,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic              timer_irq
);
    localparam int unsigned   AW         = $clog2(DEPTH_WORDS);
    localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [32:0]   RAM_BYTES  = 33'(DEPTH_WORDS) << 2;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    logic [31:0]       mem [DEPTH_WORDS];
    logic [AW-1:0]     ram_idx;
    logic              is_ram, is_mmio;
    logic [2:0]        reg_off;
    logic              ram_we, mmio_we;
    logic              wr_gpio, wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl;
    logic [N_GPIO-1:0] gpio_out_q, gpio_sync_p0, gpio_sync_p1;
    logic [PW-1:0]     presc_q;
    logic [63:0]       mtime_q, mtimecmp_q;
    logic              en_q, pend_q;
    logic              tick, pend_set, pend_clr;
    logic [31:0]       rd;

    assign is_ram  = {1'b0, bus.addr} < RAM_BYTES;
    assign is_mmio = !is_ram && (bus.addr[31:5] == MMIO_BASE[31:5]);
    assign ram_idx = bus.addr[AW+1:2];
    assign reg_off = bus.addr[4:2];

    // Writes coinciding with reset are dropped, RAM included.
    assign ram_we  = resetn && bus.mem_write && is_ram;
    assign mmio_we = bus.mem_write && is_mmio;
    assign wr_gpio = mmio_we && (reg_off == 3'd0);
    assign wr_mlo  = mmio_we && (reg_off == 3'd2) && (bus.byte_enable != 4'b0000);
    assign wr_mhi  = mmio_we && (reg_off == 3'd3) && (bus.byte_enable != 4'b0000);
    assign wr_clo  = mmio_we && (reg_off == 3'd4);
    assign wr_chi  = mmio_we && (reg_off == 3'd5);
    assign wr_ctrl = mmio_we && (reg_off == 3'd6) && bus.byte_enable[0];

    assign tick     = (presc_q == PRESC_LAST);
    assign pend_set = en_q && (mtime_q >= mtimecmp_q);
    assign pend_clr = wr_ctrl && bus.write_data[1];

    always_ff @(posedge CLOCK_50) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byte_enable[i]) mem[ram_idx][8*i +: 8] <= bus.write_data[8*i +: 8];
            end
        end
    end

    // Register block: synchroniser stages p0 -> p1, prescaler, timer and control.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            gpio_out_q   <= '0;
            gpio_sync_p0 <= '0;
            gpio_sync_p1 <= '0;
            presc_q      <= '0;
            mtime_q      <= '0;
            mtimecmp_q   <= '1;
            en_q         <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            gpio_sync_p0 <= gpio_in;
            gpio_sync_p1 <= gpio_sync_p0;
            presc_q      <= tick ? '0 : presc_q + PW'(1);

            if (wr_gpio)
                gpio_out_q <= N_GPIO'(merge_lanes(32'(gpio_out_q), bus.write_data, bus.byte_enable));

            // A software write to either half swallows that cycle's tick entirely.
            if (wr_mlo || wr_mhi) begin
                if (wr_mlo) mtime_q[31:0]  <= merge_lanes(mtime_q[31:0], bus.write_data, bus.byte_enable);
                if (wr_mhi) mtime_q[63:32] <= merge_lanes(mtime_q[63:32], bus.write_data, bus.byte_enable);
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end

            if (wr_clo) mtimecmp_q[31:0]  <= merge_lanes(mtimecmp_q[31:0], bus.write_data, bus.byte_enable);
            if (wr_chi) mtimecmp_q[63:32] <= merge_lanes(mtimecmp_q[63:32], bus.write_data, bus.byte_enable);
            if (wr_ctrl) en_q <= bus.write_data[0];

            if (pend_set)      pend_q <= 1'b1;
            else if (pend_clr) pend_q <= 1'b0;
        end
    end

    always_comb begin
        rd = 32'h0;
        if (is_ram) begin
            rd = mem[ram_idx];
        end else if (is_mmio) begin
            case (reg_off)
                3'd0:    rd = 32'(gpio_out_q);
                3'd1:    rd = 32'(gpio_sync_p1);
                3'd2:    rd = mtime_q[31:0];
                3'd3:    rd = mtime_q[63:32];
                3'd4:    rd = mtimecmp_q[31:0];
                3'd5:    rd = mtimecmp_q[63:32];
                3'd6:    rd = {30'h0, pend_q, en_q};
                default: rd = 32'h0;
            endcase
        end
    end

    assign bus.read_data = rd;
    assign gpio_out      = gpio_out_q;
    assign timer_irq     = pend_q;
endmodule

// File: tb/tb_dmem_mmio.sv
// Randomised bench for dmem_mmio against a cycle-level behavioural model of the memory map.
module tb_dmem_mmio;
    localparam int unsigned DEPTH_WORDS = 1024;
    localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
    localparam int unsigned N_GPIO      = 8;
    localparam int unsigned PRESCALE    = 50;
    localparam logic [31:0] RAM_BYTES   = DEPTH_WORDS * 4;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [7:0] gpio_in  = 8'h0;
    wire  [7:0] gpio_out;
    wire        timer_irq;

    dmem_mmio_if bus ();

    dmem_mmio #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .MMIO_BASE(MMIO_BASE),
        .N_GPIO(N_GPIO),
        .PRESCALE(PRESCALE)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .bus(bus),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .timer_irq(timer_irq)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_ram [int unsigned];
    logic [7:0]  m_gpio, m_s1, m_s2;
    logic [63:0] m_mtime, m_cmp;
    int          m_presc;
    bit          m_en, m_pend;
    int unsigned idxs [16];

    function automatic logic [31:0] put_lanes(input logic [31:0] old_val, input logic [31:0] wd,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int unsigned idx;
        int off;
        if (a < RAM_BYTES) begin
            idx = (a >> 2) % DEPTH_WORDS;
            return m_ram.exists(idx) ? m_ram[idx] : 32'hx;
        end
        if ((a & 32'hFFFF_FFE0) != MMIO_BASE) return 32'h0;
        off = int'((a - MMIO_BASE) >> 2);
        case (off)
            0:       return {24'h0, m_gpio};
            1:       return {24'h0, m_s2};
            2:       return m_mtime[31:0];
            3:       return m_mtime[63:32];
            4:       return m_cmp[31:0];
            5:       return m_cmp[63:32];
            6:       return {30'h0, m_pend, m_en};
            default: return 32'h0;
        endcase
    endfunction

    // Applies one rising edge to the model using the values the bench is driving.
    task automatic model_edge();
        logic [31:0] a, wd, t;
        logic [3:0]  be;
        logic        we;
        bit          tick, set_p, mmio;
        int          off;
        int unsigned idx;
        a = bus.addr; wd = bus.write_data; be = bus.byte_enable; we = bus.mem_write;
        if (!resetn) begin
            m_gpio = 0; m_s1 = 0; m_s2 = 0; m_mtime = 0; m_presc = 0;
            m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 0; m_pend = 0;
        end else begin
            tick  = (m_presc == PRESCALE - 1);
            set_p = m_en && (m_mtime >= m_cmp);
            mmio  = ((a & 32'hFFFF_FFE0) == MMIO_BASE);
            off   = int'((a - MMIO_BASE) >> 2);
            m_s2 = m_s1;
            m_s1 = gpio_in;
            m_presc = tick ? 0 : m_presc + 1;
            if (we && a < RAM_BYTES) begin
                idx = (a >> 2) % DEPTH_WORDS;
                t = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
                m_ram[idx] = put_lanes(t, wd, be);
            end
            if (we && mmio && (off == 2 || off == 3) && be != 4'b0000) begin
                if (off == 2) m_mtime[31:0]  = put_lanes(m_mtime[31:0], wd, be);
                else          m_mtime[63:32] = put_lanes(m_mtime[63:32], wd, be);
            end else if (tick) begin
                m_mtime = m_mtime + 64'd1;
            end
            if (we && mmio) begin
                case (off)
                    0: begin t = put_lanes({24'h0, m_gpio}, wd, be); m_gpio = t[7:0]; end
                    4: m_cmp[31:0]  = put_lanes(m_cmp[31:0], wd, be);
                    5: m_cmp[63:32] = put_lanes(m_cmp[63:32], wd, be);
                    6: if (be[0]) m_en = wd[0];
                    default: ;
                endcase
            end
            if (set_p) m_pend = 1;
            else if (we && mmio && off == 6 && be[0] && wd[1]) m_pend = 0;
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                         input logic we);
        bus.addr = a; bus.byte_enable = be; bus.write_data = wd; bus.mem_write = we;
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_edge();
        #1;
        bus.mem_write = 1'b0;
    endtask

    task automatic cyc(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                       input logic we);
        drive(a, be, wd, we);
        step();
    endtask

    task automatic idle(input int n);
        bus.mem_write = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        logic [31:0] exp_v [5];
        exp_v = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        resetn = 0;
        idle(2);
        resetn = 1;
        checks++;
        if (gpio_out !== 8'h00) begin failures++; $display("FAIL reset_gpio_out got=%h exp=00", gpio_out); end
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
        for (int i = 0; i < 5; i++) begin
            drive(MMIO_BASE + 32'(8 + 4 * i), 4'h0, 32'h0, 1'b0);
            #1;
            checks++;
            if (bus.read_data !== exp_v[i] || exp_v[i] !== m_read(bus.addr)) begin
                failures++;
                $display("FAIL reset_reg off=%0d got=%h exp=%h", 8 + 4 * i, bus.read_data, exp_v[i]);
            end
            step();
        end
    endtask

    task automatic test_ram_lanes();
        logic [31:0] a;
        int k;
        cyc(32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1);
        cyc(32'h10, 4'h1, 32'h0000_00AA, 1'b1);
        drive(32'h10, 4'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.read_data !== 32'hDEAD_BEAA) begin
            failures++; $display("FAIL ram_lane_merge got=%h exp=deadbeaa", bus.read_data);
        end
        step();
        drive(32'h12, 4'hF, 32'h1234_5678, 1'b1);
        #1;
        checks++;
        if (bus.read_data !== 32'hDEAD_BEAA) begin
            failures++; $display("FAIL ram_same_cycle got=%h exp=deadbeaa", bus.read_data);
        end
        step();
        drive(32'h13, 4'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.read_data !== 32'h1234_5678) begin
            failures++; $display("FAIL ram_next_cycle got=%h exp=12345678", bus.read_data);
        end
        step();
        for (int i = 0; i < 16; i++) idxs[i] = 32'(i * 37 + 3);
        idxs[0]  = 0;
        idxs[15] = DEPTH_WORDS - 1;
        for (int i = 0; i < 16; i++) cyc(32'(idxs[i] * 4), 4'hF, $urandom, 1'b1);
        repeat (60) begin
            k = $urandom_range(0, 15);
            cyc(32'(idxs[k] * 4 + $urandom_range(0, 3)), 4'($urandom), $urandom, 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            a = 32'(idxs[i] * 4 + $urandom_range(0, 3));
            drive(a, 4'h0, 32'h0, 1'b0);
            #1;
            checks++;
            if (bus.read_data !== m_read(a)) begin
                failures++; $display("FAIL ram_random addr=%h got=%h exp=%h", a, bus.read_data, m_read(a));
            end
            step();
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] probe [8];
        probe = '{32'h0000_1000, MMIO_BASE + 32'h1C, MMIO_BASE + 32'h20, 32'h4000_0008,
                  32'h0, 32'h10, MMIO_BASE + 32'h10, MMIO_BASE + 32'h14};
        for (int i = 0; i < 2; i++) begin
            drive(probe[i], 4'h0, 32'h0, 1'b0);
            #1;
            checks++;
            if (bus.read_data !== 32'h0) begin
                failures++; $display("FAIL unmapped_read addr=%h got=%h exp=0", probe[i], bus.read_data);
            end
            step();
        end
        for (int i = 0; i < 4; i++) cyc(probe[i], 4'hF, $urandom, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(probe[i], 4'h0, 32'h0, 1'b0);
            #1;
            checks++;
            if (bus.read_data !== m_read(probe[i])) begin
                failures++;
                $display("FAIL unmapped_side_effect addr=%h got=%h exp=%h", probe[i], bus.read_data, m_read(probe[i]));
            end
            step();
        end
    endtask

    task automatic test_gpio();
        cyc(MMIO_BASE, 4'hF, 32'h0000_01FF, 1'b1);
        checks++;
        if (gpio_out !== 8'hFF) begin failures++; $display("FAIL gpio_out_1ff got=%h exp=ff", gpio_out); end
        drive(MMIO_BASE, 4'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.read_data !== 32'h0000_00FF) begin
            failures++; $display("FAIL gpio_readback got=%h exp=000000ff", bus.read_data);
        end
        step();
        cyc(MMIO_BASE, 4'b0010, 32'h0000_AB00, 1'b1);
        checks++;
        if (gpio_out !== 8'hFF) begin failures++; $display("FAIL gpio_upper_lane got=%h exp=ff", gpio_out); end
        cyc(MMIO_BASE, 4'b0001, 32'hFFFF_FF55, 1'b1);
        checks++;
        if (gpio_out !== 8'h55) begin failures++; $display("FAIL gpio_lane0 got=%h exp=55", gpio_out); end
        gpio_in = 8'h00;
        idle(3);
        gpio_in[3] = 1'b1;
        step();
        drive(MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.read_data[3] !== 1'b0) begin
            failures++; $display("FAIL gpio_in_edge1 got=%b exp=0", bus.read_data[3]);
        end
        step();
        #1;
        checks++;
        if (bus.read_data !== 32'h0000_0008) begin
            failures++; $display("FAIL gpio_in_edge2 got=%h exp=00000008", bus.read_data);
        end
        repeat (30) begin
            gpio_in = 8'($urandom);
            drive(MMIO_BASE + 32'h4, 4'h0, 32'h0, 1'b0);
            #1;
            checks++;
            if (bus.read_data !== m_read(MMIO_BASE + 32'h4)) begin
                failures++;
                $display("FAIL gpio_in_random got=%h exp=%h", bus.read_data, m_read(MMIO_BASE + 32'h4));
            end
            step();
        end
    endtask

    task automatic test_mtime();
        logic [31:0] lo_before;
        logic [31:0] exp_v;
        resetn = 0;
        idle(1);
        resetn = 1;
        idle(499);
        drive(MMIO_BASE + 32'h8, 4'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.read_data !== 32'd9) begin failures++; $display("FAIL mtime_499 got=%0d exp=9", bus.read_data); end
        step();
        checks++;
        if (bus.read_data !== 32'd10 || m_read(MMIO_BASE + 32'h8) !== 32'd10) begin
            failures++; $display("FAIL mtime_500 got=%0d exp=10", bus.read_data);
        end
        cyc(MMIO_BASE + 32'h8, 4'hF, 32'hFFFF_FFFF, 1'b1);
        idle(50);
        for (int i = 0; i < 2; i++) begin
            exp_v = (i == 0) ? 32'h0 : 32'h1;
            drive(MMIO_BASE + 32'(8 + 4 * i), 4'h0, 32'h0, 1'b0);
            #1;
            checks++;
            if (bus.read_data !== exp_v || m_read(bus.addr) !== exp_v) begin
                failures++; $display("FAIL mtime_carry half=%0d got=%h exp=%h", i, bus.read_data, exp_v);
            end
            step();
        end
        for (int i = 0; i < PRESCALE && m_presc != PRESCALE - 1; i++) step();
        lo_before = m_mtime[31:0];
        cyc(MMIO_BASE + 32'hC, 4'hF, 32'h0000_0007, 1'b1);
        drive(MMIO_BASE + 32'h8, 4'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.read_data !== lo_before) begin
            failures++; $display("FAIL mtime_tick_drop_lo got=%h exp=%h", bus.read_data, lo_before);
        end
        step();
        drive(MMIO_BASE + 32'hC, 4'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.read_data !== 32'h7) begin
            failures++; $display("FAIL mtime_tick_drop_hi got=%h exp=7", bus.read_data);
        end
        step();
        cyc(MMIO_BASE + 32'hC, 4'hF, 32'hFFFF_FFFF, 1'b1);
        cyc(MMIO_BASE + 32'h8, 4'hF, 32'hFFFF_FFFF, 1'b1);
        idle(PRESCALE);
        for (int i = 0; i < 2; i++) begin
            drive(MMIO_BASE + 32'(8 + 4 * i), 4'h0, 32'h0, 1'b0);
            #1;
            checks++;
            if (bus.read_data !== 32'h0 || m_read(bus.addr) !== 32'h0) begin
                failures++; $display("FAIL mtime_wrap half=%0d got=%h exp=0", i, bus.read_data);
            end
            step();
        end
    endtask

    task automatic test_timer_irq();
        int c5, ci;
        resetn = 0;
        idle(1);
        resetn = 1;
        cyc(MMIO_BASE + 32'h10, 4'hF, 32'd5, 1'b1);
        cyc(MMIO_BASE + 32'h14, 4'hF, 32'd0, 1'b1);
        cyc(MMIO_BASE + 32'h18, 4'h1, 32'd1, 1'b1);
        c5 = -1;
        ci = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            checks++;
            if (timer_irq !== m_pend) begin
                failures++; $display("FAIL irq_track cycle=%0d got=%b exp=%b", i, timer_irq, m_pend);
            end
            if (c5 < 0 && m_mtime >= 64'd5) c5 = i;
            if (timer_irq === 1'b1) begin ci = i; break; end
        end
        checks++;
        if (ci < 0 || ci != c5 + 1) begin
            failures++; $display("FAIL irq_latency got_cycle=%0d exp_cycle=%0d", ci, c5 + 1);
        end
        cyc(MMIO_BASE + 32'h18, 4'h1, 32'd3, 1'b1);
        checks++;
        if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins got=%b exp=1", timer_irq); end
        cyc(MMIO_BASE + 32'h14, 4'hF, 32'd1, 1'b1);
        cyc(MMIO_BASE + 32'h18, 4'h1, 32'd3, 1'b1);
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
        cyc(MMIO_BASE + 32'h14, 4'hF, 32'd0, 1'b1);
        idle(1);
        checks++;
        if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_reraise got=%b exp=1", timer_irq); end
        cyc(MMIO_BASE + 32'h18, 4'h1, 32'd0, 1'b1);
        idle(2);
        checks++;
        if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_en_clear_keeps got=%b exp=1", timer_irq); end
        cyc(MMIO_BASE + 32'h18, 4'b1110, 32'd3, 1'b1);
        checks++;
        if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_clear_needs_lane0 got=%b exp=1", timer_irq); end
        drive(MMIO_BASE + 32'h18, 4'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.read_data !== 32'h2) begin failures++; $display("FAIL ctrl_read got=%h exp=2", bus.read_data); end
        step();
        cyc(MMIO_BASE + 32'h18, 4'h1, 32'd2, 1'b1);
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_clear_disabled got=%b exp=0", timer_irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic        we;
        int          k;
        for (int n = 0; n < 300; n++) begin
            gpio_in = 8'($urandom);
            k = $urandom_range(0, 9);
            if (k < 4)      a = 32'(idxs[$urandom_range(0, 15)] * 4 + $urandom_range(0, 3));
            else if (k < 9) a = MMIO_BASE + 32'($urandom_range(0, 7) * 4);
            else            a = ($urandom_range(0, 1) == 1) ? 32'h0001_0000 : MMIO_BASE + 32'h40;
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom);
            wd = $urandom;
            drive(a, be, wd, we);
            #1;
            checks++;
            if (bus.read_data !== m_read(a)) begin
                failures++; $display("FAIL b2b_read addr=%h got=%h exp=%h", a, bus.read_data, m_read(a));
            end
            step();
            checks++;
            if (gpio_out !== m_gpio || timer_irq !== m_pend) begin
                failures++;
                $display("FAIL b2b_pins gpio=%h irq=%b exp_gpio=%h exp_irq=%b", gpio_out, timer_irq, m_gpio, m_pend);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(MMIO_BASE, 4'hF, 32'h55, 1'b1);
        cyc(MMIO_BASE + 32'h10, 4'hF, 32'd0, 1'b1);
        cyc(MMIO_BASE + 32'h14, 4'hF, 32'd0, 1'b1);
        cyc(MMIO_BASE + 32'h18, 4'h1, 32'd1, 1'b1);
        cyc(32'(idxs[3] * 4), 4'hF, 32'hCAFE_F00D, 1'b1);
        idle(2);
        checks++;
        if (timer_irq !== 1'b1 || gpio_out !== 8'h55) begin
            failures++; $display("FAIL pre_reset irq=%b gpio=%h exp_irq=1 exp_gpio=55", timer_irq, gpio_out);
        end
        resetn = 0;
        cyc(MMIO_BASE, 4'hF, 32'hAA, 1'b1);
        resetn = 1;
        checks++;
        if (timer_irq !== 1'b0) begin failures++; $display("FAIL mid_reset_irq got=%b exp=0", timer_irq); end
        checks++;
        if (gpio_out !== 8'h00) begin failures++; $display("FAIL mid_reset_gpio got=%h exp=00", gpio_out); end
        for (int i = 0; i < 2; i++) begin
            drive(MMIO_BASE + 32'(8 + 4 * i), 4'h0, 32'h0, 1'b0);
            #1;
            checks++;
            if (bus.read_data !== 32'h0) begin
                failures++; $display("FAIL mid_reset_mtime half=%0d got=%h exp=0", i, bus.read_data);
            end
            step();
        end
        drive(32'(idxs[3] * 4), 4'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.read_data !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL mid_reset_ram got=%h exp=cafef00d", bus.read_data);
        end
        step();
    endtask

    initial begin
        drive(32'h0, 4'h0, 32'h0, 1'b0);
        test_reset();
        test_ram_lanes();
        test_unmapped();
        test_gpio();
        test_mtime();
        test_timer_irq();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
